// File: rtl/cdc_in_arb_if.sv
// Byte-stream bundle shared by the N_REQ application sources, the IN-channel arbiter
// and the USB_CDC IN channel. The arbiter takes the slave side.
interface cdc_in_arb_if #(
  parameter int N_REQ = 4
);
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ-1:0]   req_last_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         in_data_o;
  logic               in_valid_o;
  logic               in_ready_i;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;

  modport slave (
    input  req_data_i, req_valid_i, req_last_i, in_ready_i,
    output req_ready_o, in_data_o, in_valid_o, grant_o, busy_o
  );

  modport master (
    output req_data_i, req_valid_i, req_last_i, in_ready_i,
    input  req_ready_o, in_data_o, in_valid_o, grant_o, busy_o
  );
endinterface

// File: rtl/cdc_in_arbiter.sv
// Round-robin arbiter sharing the USB_CDC IN byte channel among N_REQ burst sources.
// Define CDC_IN_ARB_HEADER_EN to prefix every burst with a header byte 8'hA0 | index.
module cdc_in_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  cdc_in_arb_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

`ifdef CDC_IN_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE, GRANT, HEADER} state_t;
`else
  typedef enum logic {IDLE, GRANT} state_t;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] pick;
  logic [7:0]    sel_data;

  // Walk from the farthest candidate back to ptr+1 so the nearest valid index wins.
  always_comb begin
    pick = ptr_q;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.req_valid_i[(int'(ptr_q) + i) % N_REQ]) pick = IW'((int'(ptr_q) + i) % N_REQ);
    end
  end

  assign sel_data   = bus.req_data_i[8*gnt_q +: 8];
  assign bus.busy_o = (state_q != IDLE);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d         = state_q;
    gnt_d           = gnt_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    bus.grant_o     = '0;
    bus.req_ready_o = '0;
    bus.in_valid_o  = 1'b0;
    bus.in_data_o   = '0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          gnt_d = pick;
          ptr_d = pick;
          cnt_d = '0;
`ifdef CDC_IN_ARB_HEADER_EN
          state_d = HEADER;
`else
          state_d = GRANT;
`endif
        end
      end
`ifdef CDC_IN_ARB_HEADER_EN
      HEADER: begin
        bus.grant_o[gnt_q] = 1'b1;
        bus.in_valid_o     = 1'b1;
        bus.in_data_o      = 8'hA0 | 8'(gnt_q);
        if (bus.in_ready_i) state_d = GRANT;
      end
`endif
      GRANT: begin
        bus.grant_o[gnt_q]     = 1'b1;
        bus.in_data_o          = sel_data;
        bus.in_valid_o         = bus.req_valid_i[gnt_q];
        bus.req_ready_o[gnt_q] = bus.in_ready_i;
        if (bus.req_valid_i[gnt_q] && bus.in_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          // The compare uses the pre-increment count so MAX_BURST=1 ends on every beat.
          if (bus.req_last_i[gnt_q] || (cnt_q == LAST_CNT)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Directed bench for cdc_in_arbiter: 4 requesters, MAX_BURST=4, hand-computed expectations.
`timescale 1ns/1ps
module tb_cdc_in_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cdc_in_arb_if #(.N_REQ(N)) bus ();
  cdc_in_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic clear_inputs();
    bus.req_data_i  = '0;
    bus.req_valid_i = '0;
    bus.req_last_i  = '0;
    bus.in_ready_i  = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_byte(input int k, input logic [7:0] d, input logic v, input logic l);
    bus.req_data_i[8*k +: 8] = d;
    bus.req_valid_i[k]       = v;
    bus.req_last_i[k]        = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.req_valid_i = 4'b0101;
    next_cycle();
    next_cycle();
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b want 0000", bus.grant_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.in_valid_o !== 1'b0) begin bad++; $display("FAIL rst_in_valid: got %b want 0", bus.in_valid_o); end
    total++; if (bus.req_ready_o !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready_o); end
    total++; if (bus.in_data_o !== 8'h00) begin bad++; $display("FAIL rst_in_data: got %h want 00", bus.in_data_o); end
    next_cycle();
    rst = 1'b0;
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL rst_arb_cycle: got %b want 0000", bus.grant_o); end
    next_cycle();
    sample();
    total++; if (bus.grant_o !== 4'b0001) begin bad++; $display("FAIL rst_first_prio: got %b want 0001", bus.grant_o); end
  endtask

`ifdef CDC_IN_ARB_HEADER_EN
  task automatic test_header();
    do_reset();
    set_byte(3, 8'h55, 1'b1, 1'b1);
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL hdr_idle: got %b want 0000", bus.grant_o); end
    next_cycle();
    sample();
    total++; if (bus.in_valid_o !== 1'b1) begin bad++; $display("FAIL hdr_valid: got %b want 1", bus.in_valid_o); end
    total++; if (bus.in_data_o !== 8'hA3) begin bad++; $display("FAIL hdr_data: got %h want a3", bus.in_data_o); end
    total++; if (bus.req_ready_o !== 4'b0000) begin bad++; $display("FAIL hdr_ready: got %b want 0000", bus.req_ready_o); end
    total++; if (bus.grant_o !== 4'b1000) begin bad++; $display("FAIL hdr_grant: got %b want 1000", bus.grant_o); end
    next_cycle();
    sample();
    total++; if (bus.in_data_o !== 8'h55) begin bad++; $display("FAIL hdr_payload: got %h want 55", bus.in_data_o); end
    total++; if (bus.req_ready_o !== 4'b1000) begin bad++; $display("FAIL hdr_pay_ready: got %b want 1000", bus.req_ready_o); end
    next_cycle();
    set_byte(3, 8'h00, 1'b0, 1'b0);
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL hdr_release: got %b want 0000", bus.grant_o); end
  endtask
`else
  task automatic test_single();
    do_reset();
    set_byte(1, 8'h11, 1'b1, 1'b0);
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL single_arb: got %b want 0000", bus.grant_o); end
    total++; if (bus.in_valid_o !== 1'b0) begin bad++; $display("FAIL single_idle_valid: got %b want 0", bus.in_valid_o); end
    next_cycle();
    sample();
    total++; if (bus.grant_o !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", bus.grant_o); end
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy_o); end
    total++; if (bus.req_ready_o !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", bus.req_ready_o); end
    total++; if (bus.in_data_o !== 8'h11) begin bad++; $display("FAIL single_b0: got %h want 11", bus.in_data_o); end
    next_cycle();
    set_byte(1, 8'h22, 1'b1, 1'b0);
    sample();
    total++; if (bus.in_data_o !== 8'h22) begin bad++; $display("FAIL single_b1: got %h want 22", bus.in_data_o); end
    next_cycle();
    set_byte(1, 8'h33, 1'b1, 1'b1);
    sample();
    total++; if (bus.in_data_o !== 8'h33) begin bad++; $display("FAIL single_b2: got %h want 33", bus.in_data_o); end
    total++; if (bus.in_valid_o !== 1'b1) begin bad++; $display("FAIL single_b2_valid: got %b want 1", bus.in_valid_o); end
    next_cycle();
    set_byte(1, 8'h00, 1'b0, 1'b0);
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL single_release: got %b want 0000", bus.grant_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL single_not_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    for (int k = 0; k < N; k++) set_byte(k, 8'(8'h40 + k), 1'b1, 1'b1);
    for (int b = 0; b < 5; b++) begin
      eg = 4'(1 << (b % 4));
      ed = 8'(8'h40 + (b % 4));
      sample();
      total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL rr_bubble%0d: got %b want 0000", b, bus.grant_o); end
      next_cycle();
      sample();
      total++; if (bus.grant_o !== eg) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", b, bus.grant_o, eg); end
      total++; if (bus.in_data_o !== ed) begin bad++; $display("FAIL rr_data%0d: got %h want %h", b, bus.in_data_o, ed); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_max_burst();
    logic [3:0] eg [11];
    logic [7:0] ed [11];
    int         n2;
    logic       done0;
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
           4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
    ed = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h00, 8'h0F, 8'h00, 8'h25, 8'h26, 8'h27};
    n2    = 1;
    done0 = 1'b0;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      set_byte(2, 8'(8'h20 + n2), 1'b1, 1'b0);
      set_byte(0, 8'h0F, (c >= 1) && !done0, 1'b1);
      sample();
      total++; if (bus.grant_o !== eg[c]) begin bad++; $display("FAIL mb_grant%0d: got %b want %b", c, bus.grant_o, eg[c]); end
      if (eg[c] != 4'b0000) begin
        total++; if (bus.in_data_o !== ed[c]) begin bad++; $display("FAIL mb_data%0d: got %h want %h", c, bus.in_data_o, ed[c]); end
      end
      if (bus.req_valid_i[2] && bus.req_ready_o[2]) n2++;
      if (bus.req_valid_i[0] && bus.req_ready_o[0]) done0 = 1'b1;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic       rdy [9];
    logic [3:0] eg  [9];
    logic [3:0] er  [9];
    logic [7:0] ed  [9];
    int         n3;
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    eg  = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8};
    er  = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8};
    ed  = '{8'h00, 8'h31, 8'h32, 8'h32, 8'h32, 8'h33, 8'h34, 8'h00, 8'h35};
    n3  = 1;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      set_byte(3, 8'(8'h30 + n3), 1'b1, 1'b0);
      bus.in_ready_i = rdy[c];
      sample();
      total++; if (bus.grant_o !== eg[c]) begin bad++; $display("FAIL bp_grant%0d: got %b want %b", c, bus.grant_o, eg[c]); end
      total++; if (bus.req_ready_o !== er[c]) begin bad++; $display("FAIL bp_ready%0d: got %b want %b", c, bus.req_ready_o, er[c]); end
      total++; if (bus.in_valid_o !== (eg[c] != 4'h0)) begin bad++; $display("FAIL bp_valid%0d: got %b", c, bus.in_valid_o); end
      if (eg[c] != 4'h0) begin
        total++; if (bus.in_data_o !== ed[c]) begin bad++; $display("FAIL bp_data%0d: got %h want %h", c, bus.in_data_o, ed[c]); end
      end
      if (bus.req_valid_i[3] && bus.req_ready_o[3]) n3++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_byte(1, 8'h51, 1'b1, 1'b0);
    sample();
    next_cycle();
    sample();
    total++; if (bus.grant_o !== 4'b0010) begin bad++; $display("FAIL mid_grant: got %b want 0010", bus.grant_o); end
    next_cycle();
    set_byte(1, 8'h52, 1'b1, 1'b0);
    set_byte(0, 8'h0A, 1'b1, 1'b0);
    bus.in_ready_i = 1'b0;
    sample();
    total++; if (bus.in_data_o !== 8'h52) begin bad++; $display("FAIL mid_pending: got %h want 52", bus.in_data_o); end
    next_cycle();
    rst = 1'b1;
    sample();
    next_cycle();
    rst = 1'b0;
    bus.in_ready_i = 1'b1;
    sample();
    total++; if (bus.grant_o !== 4'b0000) begin bad++; $display("FAIL mid_rst_grant: got %b want 0000", bus.grant_o); end
    total++; if (bus.in_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.in_valid_o); end
    total++; if (bus.req_ready_o !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy_o); end
    next_cycle();
    sample();
    total++; if (bus.grant_o !== 4'b0001) begin bad++; $display("FAIL mid_regrant: got %b want 0001", bus.grant_o); end
    total++; if (bus.in_data_o !== 8'h0A) begin bad++; $display("FAIL mid_regrant_data: got %h want 0a", bus.in_data_o); end
    next_cycle();
    clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
`ifdef CDC_IN_ARB_HEADER_EN
    test_header();
`else
    test_single();
    test_round_robin();
    test_max_burst();
    test_backpressure();
    test_reset_mid_burst();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_in_arbiter.md
Name: cdc_in_arbiter

Overview:
Round-robin arbiter that shares the single USB_CDC IN byte channel (in_data/in_valid/in_ready) among N_REQ independent byte sources, e.g. loopback, LFSR generator and ROM/RAM readers.
- Grants one requester at a time for a burst.
- A burst ends on the requester's last flag or when MAX_BURST bytes have been sent, whichever comes first.
- Sits between the application sources and USB_CDC.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 64, maximum bytes per grant before forced re-arbitration (1..255)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_data_i  input  8*N_REQ  byte from requester k, at [8k+7:8k]
req_valid_i  input  N_REQ  requester k has a valid byte
req_last_i  input  N_REQ  byte from requester k is its last of a burst; qualified by valid
req_ready_o  output  N_REQ  byte from requester k consumed when valid&ready
in_data_o  output  8  byte to USB_CDC
in_valid_o  output  1  in_data_o valid
in_ready_i  input  1  USB_CDC accepts byte when valid&ready
grant_o  output  N_REQ  one-hot current grant; zero when idle
busy_o  output  1  high while a grant is held

Behaviour:
- Reset values (while rst_i high at a clk_i edge): state IDLE, grant_o=0, busy_o=0, pointer=N_REQ-1 so requester 0 has first priority, burst counter=0, in_valid_o=0, req_ready_o=0, in_data_o=0.
- States: IDLE, GRANT (HEADER added only with the optional feature).
- IDLE:
  - If any req_valid_i is high, register a grant to the first valid index searching pointer+1, pointer+2, ... modulo N_REQ.
  - Set pointer to that index, clear the burst counter, go to GRANT.
  - Arbitration takes exactly 1 cycle. No byte transfers in IDLE.
- GRANT (granted index g):
  - Datapath is combinational pass-through: in_data_o=req_data_i[g], in_valid_o=req_valid_i[g], req_ready_o[g]=in_ready_i. All other req_ready_o bits are 0.
  - On each accepted beat (in_valid_o & in_ready_i), increment the burst counter.
  - If the accepted beat has req_last_i[g]=1, or the counter reaches MAX_BURST-1 before increment, go to IDLE next cycle with grant_o=0.
  - A granted requester that drops valid keeps the grant; there is no timeout. Requesters must hold valid until a last beat.
- Fairness: after a burst from g, every other valid requester is served before g again.
- Handshake: valid and data must not change until accepted. The arbiter never asserts in_valid_o without the corresponding req_valid_i.
- Widths: burst counter is ceil_log2(MAX_BURST+1) bits. With MAX_BURST=1, every beat ends the burst.
- Simultaneous events:
  - A last beat and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle, so there is a 1-cycle bubble between bursts.
  - The pointer update uses the granted index, not the requesting set.
- Reset mid-burst: the grant is dropped immediately and any in-flight byte is not consumed (req_ready_o=0 after reset). The requester must re-present it.
- grant_o is always one-hot or zero. busy_o = (state != IDLE).

Optional Feature:
Macro CDC_IN_ARB_HEADER_EN.
- Defined:
  - IDLE transitions to HEADER instead of GRANT.
  - HEADER drives in_valid_o=1 and in_data_o = 8'hA0 | g (bits [2:0] = granted index); all req_ready_o=0.
  - On in_ready_i, go to GRANT. Header bytes are not counted in the burst counter.
  - Reset in HEADER returns to IDLE.
- Undefined: no HEADER state, no header byte, and zero added logic.

Test Plan:
- Single requester: req 1 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, in_ready_i=1 → grant_o=4'b0010 one cycle after valid; in_data_o sequence 0x11,0x22,0x33; grant_o=0 on the following cycle.
- All 4 requesters continuously valid, each burst 1 byte with last=1 → grant order 0,1,2,3,0; one idle cycle between each grant.
- MAX_BURST=4, requester 2 streams 10 bytes with no last, requester 0 also valid → 4 bytes from 2, then 0's burst, then 2 resumes with byte 5.
- Backpressure: in_ready_i toggles 1,0,0,1 during a burst → req_ready_o tracks in_ready_i; data is held and no byte is lost or duplicated; counter increments only on accepted beats.
- rst_i asserted mid-burst (byte 2 of 5 pending) → next cycle grant_o=0, in_valid_o=0, req_ready_o=0; after release, requester 0 wins if valid.
- With CDC_IN_ARB_HEADER_EN, requester 3 sends 0x55 with last=1 → in_data_o stream is 0xA3, 0x55; requester 3 is not ready during the header cycle.
